inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit producing the `inst[31:0]` stream consumed by the control decoder. It owns the PC, issues word reads to instruction memory over a valid/ready request and in-order response channel, and buffers returned words in a small FIFO. It hands instructions plus their PC to decode with a valid/ready handshake. Redirects use the decoder's `pcsrc` encoding and flush all in-flight and buffered instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries, power of two, ≥2. Also bounds outstanding requests.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `imem_req_valid` out 1: read request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word-aligned byte address, [1:0]=00.
- `imem_rsp_valid` in 1: read data valid. Exactly one response per accepted request, in order, ≥1 cycle after acceptance, no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode accepts.
- `inst` out 32: instruction word.
- `inst_pc` out 32: address of `inst`.
- `inst_pc4` out 32: `inst_pc`+4.
- `redirect_valid` in 1: control-flow change resolved this cycle.
- `redirect_src` in 2: 00 none, 01 branch, 10 jump, 11 jr.
- `redirect_pc4` in 32: PC+4 of the redirecting instruction.
- `redirect_imm` in 26: instruction bits [25:0].
- `redirect_reg` in 32: rs value, used for jr.

## Operation
- **Target computation**, all mod 2^32:
  - 01: `redirect_pc4 + (sext(redirect_imm[15:0]) << 2)`.
  - 10: `{redirect_pc4[31:28], redirect_imm, 2'b00}`.
  - 11: `{redirect_reg[31:2], 2'b00}`.
- `redirect_valid` with `redirect_src`=00 is a no-op.
- **Fetch PC:** `fetch_pc` advances by 4 on each request fire (`imem_req_valid & imem_req_ready`).
- **Credit rule:** `imem_req_valid`=1 iff not in reset, no effective redirect this cycle, and one of:
  - `count + outstanding < FIFO_DEPTH`, or
  - the sum equals `FIFO_DEPTH` and an instruction pops (`inst_valid & inst_ready`) this cycle.
- **Request hold:** once raised, request valid and address stay stable until accepted. An effective redirect is the only exception: it withdraws the request, and the next request uses the new target.
- **FSM** (2 states):
  - RUN: responses are pushed into the FIFO with their PC.
  - DRAIN: `discard_cnt` > 0; responses are dropped and `discard_cnt` decrements on each.
  - Return to RUN when `discard_cnt` reaches 0. New requests may be issued while in DRAIN; in-order return guarantees correct discard.
- **Effective redirect** (`redirect_valid` and src≠00), which beats every other event in the same cycle:
  - FIFO cleared.
  - Any same-cycle pop is void; decode must not treat it as accepted.
  - Same-cycle response dropped.
  - `fetch_pc` ← target.
  - `discard_cnt` ← `outstanding` − `imem_rsp_valid`. No request fires in a redirect cycle.
  - Enter DRAIN if the result is >0, else RUN.
- **Output:** FIFO head drives `inst`/`inst_pc`/`inst_pc4`. When `inst_valid`=0 these are 0.
- Push and pop in the same cycle on a full FIFO is legal. Responses never arrive to a full FIFO because of the credit rule; the bench asserts this.

## Timing
- **Reset** (any cycle, including mid-transfer):
  - `imem_req_valid`=0, `imem_req_addr`=0, `inst_valid`=0, `inst`=`inst_pc`=`inst_pc4`=0.
  - `fetch_pc`=`RESET_PC`, FIFO empty, outstanding=0, `discard_cnt`=0, state RUN.
  - Instruction memory shares `rst`, so no pre-reset responses arrive.
- First request: cycle after `rst` falls, with `imem_req_addr`=`RESET_PC`.
- **Latency:** request fires at cycle t, response at t+L, `inst_valid` at t+L+1.
- **Throughput:** with `imem_req_ready`=1, L=1 and `inst_ready`=1, one instruction per cycle after the first, with no gaps.
- **Redirect:** asserted at cycle r gives the first request to the target at r+1. The target instruction appears at r+1+L+1 once draining is done, or later if stale responses are still pending.
- `outstanding` ≤ `FIFO_DEPTH`; `count` ≤ `FIFO_DEPTH`.

## Structure
- `fetch_pkg`:
  - `pcsrc_t` constants `PCSRC_SEQ`=2'b00, `PCSRC_BR`=2'b01, `PCSRC_J`=2'b10, `PCSRC_JR`=2'b11.
  - FSM state enum {RUN, DRAIN}.
  - `fetch_entry_t` = {pc[31:0], inst[31:0]}.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO of `fetch_entry_t` with push, pop, clear (clear dominates), count, full, empty.

## Test plan
- **Reset/stream:** `RESET_PC`=0x100, L=1 memory, `inst_ready`=1 → requests 0x100, 0x104, 0x108 in consecutive cycles; `inst_pc` 0x100, 0x104, 0x108 on consecutive cycles starting 3 cycles after reset release.
- **Backpressure:** hold `inst_ready`=0 for 6 cycles → exactly 2 requests outstanding-or-buffered, no response overflow; release → in-order delivery, no loss or duplication.
- **Branch:** redirect src=01, pc4=0x200, imm[15:0]=0xFFFE → next request address 0x1F8.
  - Jump: src=10, pc4=0x9000_0004, imm=0x0000040 → next request address 0x9000_0100.
  - jr: src=11, reg=0x1237 → next request address 0x1234.
- **Drain:** L=3 memory, redirect with 2 requests outstanding → both stale responses dropped, state DRAIN for 2 responses, first `inst_pc` equals the target.
- **Simultaneous events:** redirect, response and pop in the same cycle → FIFO empty next cycle, response dropped, `discard_cnt` correct. src=00 with valid → no flush.
- **Mid-operation reset:** assert `rst` with full FIFO and a pending request → next cycle all outputs zero; refetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: decoder pcsrc encoding,
// fetch FSM states, buffered entry layout and redirect target math.
package fetch_pkg;

    typedef logic [1:0] pcsrc_t;

    localparam pcsrc_t PCSRC_SEQ = 2'b00;
    localparam pcsrc_t PCSRC_BR  = 2'b01;
    localparam pcsrc_t PCSRC_J   = 2'b10;
    localparam pcsrc_t PCSRC_JR  = 2'b11;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] redirect_target(
        input pcsrc_t      src,
        input logic [31:0] pc4,
        input logic [25:0] imm,
        input logic [31:0] rs_value
    );
        logic [31:0] target;
        case (src)
            PCSRC_BR: target = pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
            PCSRC_J:  target = {pc4[31:28], imm, 2'b00};
            PCSRC_JR: target = {rs_value[31:2], 2'b00};
            default:  target = pc4;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions together with their PC.
// Clear dominates push and pop; a full FIFO accepts a push alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues credit-limited word reads and
// buffers in-order responses for decode; redirects flush everything in flight.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_src,
    input  logic [31:0] redirect_pc4,
    input  logic [25:0] redirect_imm,
    input  logic [31:0] redirect_reg
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] stale_cnt;
    logic [CW:0]   in_flight;
    logic          redirect_eff;
    logic          req_fire;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;

    assign redirect_eff   = redirect_valid && (redirect_src != PCSRC_SEQ);
    assign inst_valid     = !rst && !fifo_empty;
    assign pop            = inst_valid && inst_ready && !redirect_eff;
    assign in_flight      = {1'b0, fifo_count} + {1'b0, outstanding};
    // Buffered plus outstanding words never exceed the FIFO, so a response always has room.
    assign imem_req_valid = !rst && !redirect_eff &&
                            ((in_flight < DEPTH_W) || ((in_flight == DEPTH_W) && pop));
    assign imem_req_addr  = imem_req_valid ? fetch_pc : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && (state == RUN) && !redirect_eff &&
                            (!fifo_full || pop);
    assign stale_cnt      = outstanding - CW'(imem_rsp_valid);

    assign inst     = inst_valid ? head.inst : '0;
    assign inst_pc  = inst_valid ? head.pc : '0;
    assign inst_pc4 = inst_valid ? head.pc + 32'd4 : '0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_eff),
        .push      (push),
        .push_data ('{pc: fetch_pc - (32'(outstanding) << 2), inst: imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Every request still outstanding at a redirect is stale and is dropped in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else if (redirect_eff) begin
            fetch_pc    <= redirect_target(redirect_src, redirect_pc4, redirect_imm, redirect_reg);
            outstanding <= stale_cnt;
            discard_cnt <= stale_cnt;
            state       <= (stale_cnt != '0) ? DRAIN : RUN;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= stale_cnt + CW'(req_fire);
            if ((state == DRAIN) && imem_rsp_valid) begin
                discard_cnt <= discard_cnt - CW'(1);
                if (discard_cnt == CW'(1)) state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: randomized memory latency, backpressure
// and redirects checked against a queue-based model of the fetch stream.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        redirect_valid;
    logic [1:0]  redirect_src;
    logic [31:0] redirect_pc4;
    logic [25:0] redirect_imm;
    logic [31:0] redirect_reg;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] buf_q[$];
    int          model_out;
    int          model_discard;
    logic [31:0] model_req_pc;
    int          cyc;
    int          last_due;
    int          n_checks;
    int          n_fail;
    int          lat_min;
    int          lat_max;
    int          ready_pct;
    int          pop_pct;
    int          redir_pct;
    logic        force_redir;
    logic [1:0]  f_src;
    logic [31:0] f_pc4;
    logic [25:0] f_imm;
    logic [31:0] f_reg;

    inst_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4),
        .redirect_valid (redirect_valid),
        .redirect_src   (redirect_src),
        .redirect_pc4   (redirect_pc4),
        .redirect_imm   (redirect_imm),
        .redirect_reg   (redirect_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] pc4,
                                               input logic [25:0] imm, input logic [31:0] rs);
        int off;
        off = int'($signed(imm[15:0]));
        case (src)
            2'b01:   return pc4 + 32'(off * 4);
            2'b10:   return (pc4 & 32'hF000_0000) | ({6'b0, imm} << 2);
            2'b11:   return rs & 32'hFFFF_FFFC;
            default: return pc4;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compares DUT outputs with the model, then advances memory and model by one cycle.
    task automatic modelStep();
        logic        eff;
        logic        exp_valid;
        logic        exp_req;
        logic        pop;
        logic [31:0] rsp_pc;
        int          in_flight;
        int          lat;
        if (rst) begin
            checkOutput("rst_req_valid", imem_req_valid, 0);
            checkOutput("rst_req_addr", imem_req_addr, 0);
            checkOutput("rst_inst_valid", inst_valid, 0);
            checkOutput("rst_inst", inst, 0);
            checkOutput("rst_inst_pc", inst_pc, 0);
            checkOutput("rst_inst_pc4", inst_pc4, 0);
            pend_q.delete();
            buf_q.delete();
            model_out     = 0;
            model_discard = 0;
            model_req_pc  = RESET_PC;
            last_due      = 0;
            return;
        end
        eff       = redirect_valid && (redirect_src != 2'b00);
        exp_valid = (buf_q.size() > 0);
        checkOutput("inst_valid", inst_valid, exp_valid);
        if (exp_valid) begin
            checkOutput("inst", inst, mem_word(buf_q[0]));
            checkOutput("inst_pc", inst_pc, buf_q[0]);
            checkOutput("inst_pc4", inst_pc4, buf_q[0] + 32'd4);
        end else begin
            checkOutput("inst_idle", inst, 0);
            checkOutput("inst_pc_idle", inst_pc, 0);
        end
        pop       = exp_valid && inst_ready && !eff;
        in_flight = model_out + buf_q.size();
        exp_req   = !eff && ((in_flight < DEPTH) || ((in_flight == DEPTH) && pop));
        checkOutput("req_valid", imem_req_valid, exp_req);
        if (exp_req) checkOutput("req_addr", imem_req_addr, model_req_pc);

        rsp_pc = '0;
        if (imem_rsp_valid && pend_q.size() > 0) begin
            rsp_pc = pend_q[0].addr;
            void'(pend_q.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            lat      = int'($urandom_range(lat_max, lat_min));
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend_q.push_back('{addr: imem_req_addr, due: last_due});
        end

        if (eff) begin
            buf_q.delete();
            model_out     = model_out - int'(imem_rsp_valid);
            model_discard = model_out;
            model_req_pc  = ref_target(redirect_src, redirect_pc4, redirect_imm, redirect_reg);
        end else begin
            if (pop) void'(buf_q.pop_front());
            if (imem_rsp_valid) begin
                model_out--;
                if (model_discard > 0) begin
                    model_discard--;
                end else begin
                    checkOutput("no_overflow", buf_q.size() < DEPTH, 1);
                    buf_q.push_back(rsp_pc);
                end
            end
            if (exp_req && imem_req_ready) begin
                model_out++;
                model_req_pc = model_req_pc + 32'd4;
            end
        end
    endtask

    task automatic applyStimulus(input logic do_reset);
        @(posedge clk);
        #1;
        cyc++;
        rst            = do_reset;
        imem_req_ready = (int'($urandom_range(99)) < ready_pct);
        inst_ready     = (int'($urandom_range(99)) < pop_pct);
        if (!do_reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect_src = 2'($urandom);
        redirect_pc4 = $urandom & 32'hFFFF_FFFC;
        redirect_imm = 26'($urandom);
        redirect_reg = $urandom;
        if (do_reset) begin
            redirect_valid = 1'b0;
        end else if (force_redir) begin
            force_redir    = 1'b0;
            redirect_valid = 1'b1;
            redirect_src   = f_src;
            redirect_pc4   = f_pc4;
            redirect_imm   = f_imm;
            redirect_reg   = f_reg;
        end else begin
            redirect_valid = (int'($urandom_range(99)) < redir_pct);
        end
        @(negedge clk);
        modelStep();
    endtask

    task automatic forceRedirect(input logic [1:0] src, input logic [31:0] pc4,
                                 input logic [25:0] imm, input logic [31:0] rs);
        force_redir = 1'b1;
        f_src = src;
        f_pc4 = pc4;
        f_imm = imm;
        f_reg = rs;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_src = '0;
        redirect_pc4 = '0;
        redirect_imm = '0;
        redirect_reg = '0;
        force_redir = 1'b0;
        f_src = '0; f_pc4 = '0; f_imm = '0; f_reg = '0;
        cyc = 0; last_due = 0; n_checks = 0; n_fail = 0;
        model_out = 0; model_discard = 0; model_req_pc = RESET_PC;
        lat_min = 1; lat_max = 1; ready_pct = 100; pop_pct = 100; redir_pct = 0;

        repeat (3) applyStimulus(1'b1);

        // Back-to-back stream straight out of reset.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0);
            if (k < 3) begin
                checkOutput("stream_req_valid", imem_req_valid, 1);
                checkOutput("stream_req_addr", imem_req_addr, RESET_PC + 32'(4 * k));
            end
            if (k >= 2 && k < 5) begin
                checkOutput("stream_inst_valid", inst_valid, 1);
                checkOutput("stream_inst_pc", inst_pc, RESET_PC + 32'(4 * (k - 2)));
            end
        end

        pop_pct = 0;
        repeat (6) applyStimulus(1'b0);
        checkOutput("bp_inst_valid", inst_valid, 1);
        checkOutput("bp_req_blocked", imem_req_valid, 0);
        pop_pct = 100;
        repeat (10) applyStimulus(1'b0);

        // Redirect coinciding with a response and a pop must flush both.
        forceRedirect(2'b01, 32'h0000_0200, 26'h000_FFFE, 32'h0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("br_req_valid", imem_req_valid, 1);
        checkOutput("br_req_addr", imem_req_addr, 32'h0000_01F8);
        checkOutput("br_flushed", inst_valid, 0);
        repeat (5) applyStimulus(1'b0);

        forceRedirect(2'b10, 32'h9000_0004, 26'h000_0040, 32'h0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("j_req_addr", imem_req_addr, 32'h9000_0100);
        repeat (5) applyStimulus(1'b0);

        forceRedirect(2'b11, 32'h0, 26'h0, 32'h0000_1237);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("jr_req_addr", imem_req_addr, 32'h0000_1234);
        repeat (5) applyStimulus(1'b0);

        forceRedirect(2'b00, 32'h0000_7000, 26'h0, 32'h0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("seq_no_flush", inst_valid, 1);
        repeat (3) applyStimulus(1'b0);

        // Long latency: redirect with stale requests in flight.
        lat_min = 3; lat_max = 3;
        for (int w = 0; w < 12 && model_out != 2; w++) applyStimulus(1'b0);
        forceRedirect(2'b11, 32'h0, 26'h0, 32'h0000_4000);
        applyStimulus(1'b0);
        for (int w = 0; w < 20 && !inst_valid; w++) applyStimulus(1'b0);
        checkOutput("drain_first_valid", inst_valid, 1);
        checkOutput("drain_first_pc", inst_pc, 32'h0000_4000);

        // Reset while the buffer is full and a request is pending.
        lat_min = 2; lat_max = 2; pop_pct = 0;
        repeat (6) applyStimulus(1'b0);
        repeat (2) applyStimulus(1'b1);
        pop_pct = 100;
        applyStimulus(1'b0);
        checkOutput("refetch_valid", imem_req_valid, 1);
        checkOutput("refetch_addr", imem_req_addr, RESET_PC);
        repeat (4) applyStimulus(1'b0);

        for (int p = 0; p < 4; p++) begin
            lat_min = 1; lat_max = p + 1;
            ready_pct = 55 + 15 * p; pop_pct = 85 - 15 * p; redir_pct = 7;
            repeat (600) applyStimulus(int'($urandom_range(299)) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
